// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a registered one-hot grant,
// owner-driven release, a hold watchdog and a one-cycle turnaround gap.
module rr_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic             WD_EN     = (MAX_HOLD != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] hold_cnt;

  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] win_idx;
  logic             win_valid;
  logic             rel_normal;
  logic             wd_hit;
  logic             release_now;

  // Rotating priority scan; descending offsets so the lowest offset from ptr wins.
  always_comb begin
    cand      = ptr;
    win_idx   = ptr;
    win_valid = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + IDX_W'(k);
      if (req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // A voluntary release masks a simultaneous watchdog expiry.
  always_comb begin
    rel_normal  = done | ~req[gnt_idx];
    wd_hit      = WD_EN && (hold_cnt == HOLD_LAST);
    release_now = rel_normal | wd_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= 4'b0000;
      gnt_idx   <= 2'b00;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      ptr       <= 2'b00;
      hold_cnt  <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE, GAP: begin
          if (en && win_valid) begin
            state     <= BUSY;
            gnt       <= 4'b0001 << win_idx;
            gnt_idx   <= win_idx;
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (release_now) begin
            state     <= GAP;
            gnt       <= 4'b0000;
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + 2'd1;
            timeout   <= wd_hit & ~rel_normal;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
